// File: rtl/ir_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ir_fetch_pkg : shared types and constants for the fetch unit          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ir_fetch_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry synchronous FIFO with flush                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_fifo
    import ir_fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    T              mem_q [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (w_push) wr_d = wr_q + PW'(1);
            if (w_pop)  rd_d = rd_q + PW'(1);
            if (w_push && !w_pop)      cnt_d = cnt_q + CW'(1);
            else if (w_pop && !w_push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/ir_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ir_fetch : sequential instruction fetch with redirect and fault halt  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ir_fetch
    import ir_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_fault,
    input  logic        ir_ready
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;

    fetch_entry_t  buf_in, buf_out;
    logic [CW-1:0] buf_count, pcq_count;
    logic          buf_empty, buf_full, pcq_empty, pcq_full;
    logic [31:0]   pcq_head;

    logic          w_pop, w_req, w_acc, w_rsp, w_keep;
    logic [CW:0]   w_occ;

    // Credit counts the slot freed by this cycle's pop so k=1 streams at full rate.
    assign w_pop  = !buf_empty && ir_ready;
    assign w_occ  = {1'b0, buf_count} + {1'b0, pcq_count} - {{CW{1'b0}}, w_pop};
    assign w_req  = rst_n && (state_q == FETCH_RUN) && !redirect_valid
                    && !pcq_full && !(buf_full && !w_pop) && (w_occ < DEPTH_W);
    assign w_acc  = w_req && imem_req_ready;
    assign w_rsp  = imem_rsp_valid && !pcq_empty;
    assign w_keep = w_rsp && !redirect_valid && (drop_q == '0);

    assign buf_in = '{instr: imem_rsp_err ? INSTR_NOP : imem_rsp_data,
                      pc:    pcq_head,
                      fault: imem_rsp_err};

    always_comb begin
        pc_d    = pc_q;
        drop_d  = drop_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'h3;
            drop_d  = pcq_count - CW'(w_rsp);
            state_d = FETCH_RUN;
        end else begin
            if (w_acc) pc_d = pc_q + 32'd4;
            if (w_rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (w_keep && imem_rsp_err) state_d = FETCH_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            state_q <= FETCH_RUN;
        end else begin
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            state_q <= state_d;
        end
    end

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_keep),
        .data_i  (buf_in),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .data_o  (buf_out),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    // Never flushed: stale responses still arrive and must pop their PC.
    fetch_fifo #(
        .T     (logic [31:0]),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_acc),
        .data_i  (pc_q),
        .pop_i   (w_rsp),
        .flush_i (1'b0),
        .data_o  (pcq_head),
        .count_o (pcq_count),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    assign imem_req_valid = w_req;
    assign imem_req_addr  = pc_q;
    assign ir_valid       = !buf_empty;
    assign ir             = ir_valid ? buf_out.instr : INSTR_NOP;
    assign ir_pc          = ir_valid ? buf_out.pc : 32'h0;
    assign ir_fault       = ir_valid && buf_out.fault;

endmodule
`default_nettype wire

// File: tb/tb_ir_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ir_fetch : randomized bench for ir_fetch with reference model      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ir_fetch;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_fault;
    logic        ir_ready;

    always #5 clk = ~clk;

    ir_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_fault       (ir_fault),
        .ir_ready       (ir_ready)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; logic err; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic fault; } exp_t;

    req_t        inflight[$];
    exp_t        expq[$];
    logic [31:0] acc_log[$];
    int          total = 0, bad = 0;
    int          cyc = 0, epoch = 0, last_due = 0, n_acc = 0;
    bit          halted = 1'b0;
    logic [31:0] exp_pc = RST_PC;

    int          p_ready = 100, p_mready = 100, k_lo = 1, k_hi = 1, p_redir = 0, p_err = 0;
    logic [31:0] err_addr = 32'h1;
    bit          f_redir = 1'b0;
    logic [31:0] f_rpc = 32'h0;

    logic        s_valid, s_fault, s_reqv;
    logic [31:0] s_ir, s_pc, s_raddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model.
    task automatic step();
        req_t        r;
        bit          pop;
        int          due;
        ir_ready       = ($urandom_range(0, 99) < p_ready);
        imem_req_ready = ($urandom_range(0, 99) < p_mready);
        if (f_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = f_rpc;
            f_redir        = 1'b0;
        end else if (p_redir > 0 && $urandom_range(0, 999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
        end else begin
            redirect_valid = 1'b0;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
        if (inflight.size() > 0 && inflight[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(inflight[0].addr);
            imem_rsp_err   = inflight[0].err;
        end
        #1;
        s_valid = ir_valid; s_fault = ir_fault; s_ir = ir; s_pc = ir_pc;
        s_reqv  = imem_req_valid; s_raddr = imem_req_addr;

        check_eq("ir_valid", ir_valid, expq.size() != 0);
        if (expq.size() != 0) begin
            check_eq("ir", ir, expq[0].instr);
            check_eq("ir_pc", ir_pc, expq[0].pc);
            check_eq("ir_fault", ir_fault, expq[0].fault);
        end else begin
            check_eq("ir_idle", ir, NOP_W);
        end
        pop = (expq.size() != 0) && ir_ready;
        if (halted || redirect_valid)
            check_eq("req_blocked", imem_req_valid, 0);
        else if (expq.size() == 0 && inflight.size() == 0)
            check_eq("req_live", imem_req_valid, 1);
        if (imem_req_valid) begin
            check_eq("req_addr", imem_req_addr, exp_pc);
            check_eq("credit", (expq.size() - int'(pop) + inflight.size()) < DEPTH, 1);
        end

        if (pop) void'(expq.pop_front());
        if (redirect_valid) begin
            epoch++;
            expq.delete();
            halted = 1'b0;
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        if (imem_rsp_valid) begin
            r = inflight.pop_front();
            if (r.epoch == epoch) begin
                expq.push_back('{instr: r.err ? NOP_W : mem_word(r.addr), pc: r.addr, fault: r.err});
                if (r.err) halted = 1'b1;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + $urandom_range(k_lo, k_hi);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            inflight.push_back('{addr: exp_pc, epoch: epoch, due: due,
                                 err: (exp_pc == err_addr) || ($urandom_range(0, 99) < p_err)});
            acc_log.push_back(imem_req_addr);
            n_acc++;
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; ir_ready = 1'b0;
        #1;
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_ir_valid", ir_valid, 0);
        check_eq("rst_ir", ir, NOP_W);
        check_eq("rst_ir_pc", ir_pc, 32'h0);
        check_eq("rst_ir_fault", ir_fault, 0);
        inflight.delete(); expq.delete();
        halted = 1'b0; epoch++; exp_pc = RST_PC; last_due = cyc;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, nvalid, a0;
        ir_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; imem_rsp_err = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        @(negedge clk);
        do_reset();

        // Streaming from RESET_PC with k=1
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 2) check_eq("first_pc", s_pc, RST_PC);
            nvalid += int'(s_valid);
        end
        check_eq("throughput", nvalid, 18);

        // Decode stall
        p_ready = 0; a0 = n_acc;
        repeat (10) step();
        check_eq("stall_reqs", (n_acc - a0) <= DEPTH, 1);
        check_eq("stall_req_off", s_reqv, 0);
        check_eq("stall_hold", s_valid, 1);
        p_ready = 100;
        repeat (10) step();

        // Redirect with two requests in flight
        k_lo = 3; k_hi = 3; n = 0;
        while (inflight.size() != 2 && n < 20) begin step(); n++; end
        check_eq("pend2", inflight.size(), 2);
        f_redir = 1'b1; f_rpc = 32'h2000;
        step();
        step();
        check_eq("redir_flush", s_valid, 0);
        n = 0;
        while (!s_valid && n < 20) begin step(); n++; end
        check_eq("redir_pc", s_pc, 32'h2000);

        // Access fault at 0x40, then resume at 0x80
        k_lo = 1; k_hi = 1; err_addr = 32'h40;
        f_redir = 1'b1; f_rpc = 32'h38;
        step();
        n = 0;
        while (!(s_valid && s_fault) && n < 30) begin step(); n++; end
        check_eq("fault_seen", s_fault, 1);
        check_eq("fault_pc", s_pc, 32'h40);
        check_eq("fault_ir", s_ir, NOP_W);
        a0 = n_acc;
        repeat (6) step();
        check_eq("halt_noreq", n_acc - a0, 0);
        err_addr = 32'h1;
        f_redir = 1'b1; f_rpc = 32'h80;
        step();
        step();
        n = 0;
        while (!s_valid && n < 20) begin step(); n++; end
        check_eq("resume_pc", s_pc, 32'h80);

        // Address wrap
        acc_log.delete();
        f_redir = 1'b1; f_rpc = 32'hFFFF_FFF8;
        step();
        n = 0;
        while (acc_log.size() < 3 && n < 20) begin step(); n++; end
        check_eq("wrap_cnt", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            check_eq("wrap0", acc_log[0], 32'hFFFF_FFF8);
            check_eq("wrap1", acc_log[1], 32'hFFFF_FFFC);
            check_eq("wrap2", acc_log[2], 32'h0000_0000);
        end
        repeat (5) step();

        // Randomized traffic
        p_ready = 70; p_mready = 70; k_lo = 1; k_hi = 4; p_redir = 15; p_err = 3;
        repeat (800) step();

        // Reset with work in flight
        p_ready = 100; p_mready = 100; p_redir = 0; p_err = 0; k_lo = 2; k_hi = 2;
        f_redir = 1'b1; f_rpc = 32'h500;
        step();
        p_ready = 0;
        repeat (3) step();
        do_reset();
        p_ready = 100; k_lo = 1; k_hi = 1;
        step();
        check_eq("restart_req", s_reqv, 1);
        check_eq("restart_addr", s_raddr, RST_PC);
        repeat (15) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch unit: the producer of the 32-bit `ir` word consumed by `ir_decoder`. It issues sequential word fetches to instruction memory, buffers returned words with their PC, and presents them to decode over a valid/ready handshake. It accepts PC redirects from execute (branches, jumps, traps) and flushes stale work. It sits between the instruction-memory port and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: buffer entries; also the maximum number of requests in flight. Power of two, 2..8.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: word address; bits [1:0] are always 0.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response word valid. Responses return in order, no backpressure.
- `imem_rsp_data` in 32: fetched instruction.
- `imem_rsp_err` in 1: access fault for this response.
- `redirect_valid` in 1: replace the fetch PC.
- `redirect_pc` in 32: new PC. Bits [1:0] are forced to 0.
- `ir_valid` out 1: an instruction is presented to decode.
- `ir` out 32: instruction word; `INSTR_NOP` when `ir_valid`=0.
- `ir_pc` out 32: PC of `ir`.
- `ir_fault` out 1: `ir` is a fault marker, not a valid instruction.
- `ir_ready` in 1: decode accepts `ir`.

## Operation
- States: RUN, HALT.
  - RUN issues fetches.
  - On accepting a response with `imem_rsp_err`=1, the block enqueues a fault entry (data = `INSTR_NOP`, `ir_fault`=1) and moves to HALT.
  - HALT issues no requests. Only a redirect returns the block to RUN.
- Issue rule: `imem_req_valid` = (state==RUN) && !`redirect_valid` && (count + outstanding < DEPTH). `imem_req_addr` = `pc`.
- On `imem_req_valid && imem_req_ready`: `pc` <= `pc` + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0). `outstanding` increments and the request's PC is pushed onto an in-flight PC queue.
- On response: `outstanding` decrements and the PC queue pops.
  - If `drop` > 0, the response is discarded and `drop` decrements.
  - Otherwise the entry {data, pc, err} is pushed into the buffer.
  - Overflow is impossible by the credit rule.
- Pop: when `ir_valid && ir_ready`.
- Redirect cycle:
  - A pop in this same cycle still completes.
  - A response arriving in this cycle is discarded.
  - The buffer is cleared.
  - `drop` <= outstanding after this cycle's response.
  - `pc` <= `redirect_pc`; state <= RUN.
  - The first request for the new PC can go out on the next cycle.
- Push and pop in the same cycle with a full buffer: both take effect, and count is unchanged.

## Timing
- Reset values:
  - Outputs: `imem_req_valid`=0, `ir_valid`=0, `ir`=`INSTR_NOP`, `ir_pc`=0, `ir_fault`=0.
  - Internal: `pc`=`RESET_PC`, count=outstanding=drop=0, state=RUN.
- The first request is asserted in the first cycle after `rst_n` rises. Asserting `rst_n` low mid-transfer drops everything; responses to pre-reset requests must not be issued by memory (system guarantee).
- Latency: request accepted in cycle N, response in N+k (k≥1), `ir_valid` in N+k+1. There is no bypass from response to `ir`.
- `ir`, `ir_pc`, `ir_fault` are stable while `ir_valid`=1 and `ir_ready`=0.
- Throughput is one instruction per cycle with DEPTH≥2 and k=1.
- `imem_req_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0, unless a redirect arrives; a redirect withdraws the request in that cycle.

## Structure
- In the shared `datatypes.sv` package:
  - `INSTR_NOP` = 32'h0000_0013 (addi x0,x0,0).
  - `fetch_entry_t` packed struct {logic [31:0] instr; logic [31:0] pc; logic fault;}.
  - `fetch_state_t` enum {FETCH_RUN, FETCH_HALT}.
- Sub-module `fetch_fifo`: DEPTH-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, empty and full, and asynchronous active-low reset. It is instantiated twice: once as the instruction buffer and once (payload = pc) as the in-flight PC queue.

## Test plan
- Reset, `RESET_PC`=0x100, memory always ready with k=1, `ir_ready`=1: requests go to 0x100, 0x104, 0x108…; `ir_pc` follows the same sequence one instruction per cycle after a 2-cycle fill; `ir` matches the memory contents.
- `ir_ready`=0 for 10 cycles: at most DEPTH requests issue, then `imem_req_valid`=0. `ir`/`ir_pc` hold. After `ir_ready`=1, no instruction is lost or duplicated.
- Redirect to 0x2000 with 2 requests outstanding (k=3): both stale responses are dropped; the next `ir_pc` is 0x2000; the buffer is empty in the cycle after the redirect.
- Response with `imem_rsp_err`=1 at 0x40: `ir_fault`=1 with `ir_pc`=0x40 and `ir`=0x00000013; no further requests issue until a redirect to 0x80 resumes fetching at 0x80.
- `pc`=0xFFFF_FFF8: requests go to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- `rst_n` asserted with a full buffer and requests in flight: all outputs return to their reset values asynchronously, and fetch restarts at `RESET_PC`.
